// File: rtl/skinny_sbox8_isw1_sequencer.sv
// Handshake sequencer for a non-pipelined ISW SKINNY sbox8: holds shares and mask for LATENCY cycles, then captures the result.
// Define SKINNY_SEQ_EXT_RAND_EN to take the refresh mask from an external rnd port instead of the internal LFSR.
module skinny_sbox8_isw1_sequencer #(
  parameter int unsigned LATENCY   = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] din1,
  input  logic [7:0] din0,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] dout1,
  output logic [7:0] dout0,
  output logic [7:0] si1,
  output logic [7:0] si0,
  output logic [7:0] r,
  input  logic [7:0] bo1,
  input  logic [7:0] bo0,
`ifdef SKINNY_SEQ_EXT_RAND_EN
  input  logic [7:0] rnd,
`endif
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [3:0] LAT4 = 4'(LATENCY);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [7:0] si1_q, si0_q, r_q;
  logic [7:0] dout1_q, dout0_q;
  logic       out_valid_q;
  logic [7:0] mask_src;

`ifdef SKINNY_SEQ_EXT_RAND_EN
  assign mask_src = rnd;
`else
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci shift-left, taps 15/13/12/10 feed bit 0
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign mask_src = lfsr_q[7:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      si1_q       <= '0;
      si0_q       <= '0;
      r_q         <= '0;
      dout1_q     <= '0;
      dout0_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            si1_q   <= din1;
            si0_q   <= din0;
            r_q     <= mask_src;
            cnt_q   <= '0;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          // cnt is cleared on exit so it never climbs past LATENCY
          if (cnt_q == LAT4) begin
            dout1_q     <= bo1;
            dout0_q     <= bo0;
            si1_q       <= '0;
            si0_q       <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            dout1_q     <= '0;
            dout0_q     <= '0;
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign dout1     = dout1_q;
  assign dout0     = dout0_q;
  assign si1       = si1_q;
  assign si0       = si0_q;
  assign r         = r_q;

endmodule

// File: tb/tb_skinny_sbox8_isw1_sequencer.sv
// Bench for skinny_sbox8_isw1_sequencer with a behavioural ISW sbox8 (register depth LAT) and LFSR reference.
module tb_skinny_sbox8_isw1_sequencer;
  localparam int unsigned LAT  = 8;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] din1 = '0, din0 = '0;
  logic       in_ready, out_valid, busy;
  logic [7:0] dout1, dout0, si1, si0, r, bo1, bo0;
`ifdef SKINNY_SEQ_EXT_RAND_EN
  logic [7:0] rnd = '0;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] lfsr_m;
  logic [23:0] pipe [LAT];

  skinny_sbox8_isw1_sequencer #(.LATENCY(LAT), .LFSR_SEED(SEED)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .din1(din1), .din0(din0),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout1(dout1), .dout0(dout0),
    .si1(si1), .si0(si0), .r(r),
    .bo1(bo1), .bo0(bo0),
`ifdef SKINNY_SEQ_EXT_RAND_EN
    .rnd(rnd),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // SKINNY 8-bit sbox: four NOR/XOR layers, bit permutation between, final swap of bits 1 and 2
  function automatic logic [7:0] sbox8(input logic [7:0] v);
    logic [7:0] x;
    x = v;
    for (int i = 0; i < 4; i++) begin
      x[4] = x[4] ^ ~(x[7] | x[6]);
      x[0] = x[0] ^ ~(x[3] | x[2]);
      if (i < 3) x = {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
      else       x = {x[7:3], x[1], x[2], x[0]};
    end
    return x;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= SEED;
    else     lfsr_m <= {lfsr_m[14:0], ^(lfsr_m & 16'hB400)};
  end

  // Sbox model: inputs travel LAT register stages, output shares are re-masked with r
  always @(posedge clk) begin
    pipe[0] <= {si1, si0, r};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  always_comb begin
    bo0 = pipe[LAT-1][7:0];
    bo1 = sbox8(pipe[LAT-1][23:16] ^ pipe[LAT-1][15:8]) ^ pipe[LAT-1][7:0];
  end

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    in_valid = 1'($urandom_range(0, 1));
    din1     = 8'($urandom);
    din0     = 8'($urandom);
`ifdef SKINNY_SEQ_EXT_RAND_EN
    rnd      = 8'($urandom);
`endif
  endtask

  task automatic run_op(input logic [7:0] a1, input logic [7:0] a0, input logic [7:0] rx,
                        input int unsigned stall, output logic [7:0] r_obs, output logic [7:0] r_exp);
    logic [7:0] sv;
    in_valid = 1'b1;
    din1 = a1;
    din0 = a0;
`ifdef SKINNY_SEQ_EXT_RAND_EN
    rnd   = rx;
    r_exp = rx;
`else
    r_exp = lfsr_m[7:0];
`endif
    out_ready = (stall == 0);
    sv = sbox8(a1 ^ a0);
    chk1("in_ready_idle", in_ready, 1'b1);
    chk1("busy_idle", busy, 1'b0);
    tick();
    noise();
    r_obs = r;
    chk8("si1_accept", si1, a1);
    chk8("si0_accept", si0, a0);
    chk8("r_accept", r, r_exp);
    chk1("busy_hold", busy, 1'b1);
    chk1("in_ready_hold", in_ready, 1'b0);
    for (int unsigned k = 1; k <= LAT; k++) begin
      tick();
      noise();
      chk1("out_valid_early", out_valid, 1'b0);
      chk8("si1_stable", si1, a1);
      chk8("si0_stable", si0, a0);
      chk8("r_stable", r, r_exp);
    end
    tick();
    noise();
    chk1("out_valid_rise", out_valid, 1'b1);
    chk8("dout1", dout1, sv ^ r_exp);
    chk8("dout0", dout0, r_exp);
    chk8("dout_xor", dout1 ^ dout0, sv);
    chk8("si1_cleared", si1, 8'h00);
    chk8("si0_cleared", si0, 8'h00);
    chk8("r_cleared", r, 8'h00);
    for (int unsigned s = 0; s < stall; s++) begin
      tick();
      noise();
      chk1("out_valid_hold", out_valid, 1'b1);
      chk1("in_ready_stall", in_ready, 1'b0);
      chk8("dout1_hold", dout1, sv ^ r_exp);
      chk8("dout0_hold", dout0, r_exp);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk1("out_valid_fall", out_valid, 1'b0);
    chk1("in_ready_back", in_ready, 1'b1);
    chk1("busy_back", busy, 1'b0);
    chk8("dout1_clear", dout1, 8'h00);
    chk8("dout0_clear", dout0, 8'h00);
  endtask

  // Accept, run n_edges further edges, then pulse rst asynchronously
  task automatic abort_op(input logic [7:0] a1, input logic [7:0] a0, input int unsigned n_edges,
                          input logic ordy);
    in_valid  = 1'b1;
    din1      = a1;
    din0      = a0;
    out_ready = ordy;
    tick();
    in_valid = 1'b0;
    for (int unsigned k = 0; k < n_edges; k++) tick();
    chk1("pre_abort_valid", out_valid, 1'(n_edges >= LAT + 1));
    rst = 1'b1;
    #1;
    chk1("abort_out_valid", out_valid, 1'b0);
    chk8("abort_si1", si1, 8'h00);
    chk8("abort_si0", si0, 8'h00);
    chk8("abort_r", r, 8'h00);
    chk8("abort_dout1", dout1, 8'h00);
    chk8("abort_dout0", dout0, 8'h00);
    tick();
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    chk1("abort_in_ready", in_ready, 1'b1);
    chk1("abort_busy", busy, 1'b0);
    for (int unsigned k = 0; k < LAT + 3; k++) begin
      tick();
      chk1("abort_no_pulse", out_valid, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb, ea, eb, a1, a0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk8("rst_si1", si1, 8'h00);
    chk8("rst_si0", si0, 8'h00);
    chk8("rst_r", r, 8'h00);
    chk8("rst_dout1", dout1, 8'h00);
    chk8("rst_dout0", dout0, 8'h00);
    rst = 1'b0;
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);

    run_op(8'h00, 8'h00, 8'h17, 0, ra, ea);
    run_op(8'h5A, 8'hA5, 8'hC3, 0, ra, ea);
    run_op(8'($urandom), 8'($urandom), 8'($urandom), 20, ra, ea);

    run_op(8'($urandom), 8'($urandom), 8'h21, 0, ra, ea);
    run_op(8'($urandom), 8'($urandom), 8'h9E, 0, rb, eb);
    chk1("r_differs", 1'(ra != rb), 1'(ea != eb));

    abort_op(8'h3C, 8'hC3, 4, 1'b1);
    run_op(8'h12, 8'h34, 8'h3C, 0, ra, ea);
    abort_op(8'h77, 8'h01, LAT + 3, 1'b0);
    run_op(8'hFE, 8'h01, 8'h55, 1, ra, ea);

    for (int unsigned n = 0; n < 256; n++) begin
      a1 = 8'($urandom);
      a0 = 8'($urandom);
      run_op(a1, a0, 8'($urandom), ($urandom_range(0, 3) == 0) ? 2 : 0, ra, ea);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
